// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX operand info and redirect in, stall/flush controls and perf counters out.
interface hazard_ctrl_if;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        use_rs;
  logic        use_rt;
  logic [4:0]  rttoEX;
  logic        MentoRegtoEX;
  logic        RegWrtoEX;
  logic        redirect_ex;
  logic        loadad;
  logic        jumpSuccess;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs, rt, use_rs, use_rt, rttoEX, MentoRegtoEX, RegWrtoEX, redirect_ex,
    input  loadad, jumpSuccess, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, rttoEX, MentoRegtoEX, RegWrtoEX, redirect_ex,
    output loadad, jumpSuccess, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX-redirect flush controller feeding the ID/EX, IF/ID and PC hold logic.
// Define HAZARD_PERF_CNT_EN to build the stall/flush cycle counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
);

  // state | meaning
  // IDLE  | no extension in progress
  // STALL | holding loadad for the remaining cycles of a load-use stall
  // FLUSH | holding jumpSuccess for the remaining cycles of a redirect
  typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_FLUSH} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_rem, w_rem_nxt;
  logic       w_lu_hit;
  logic       w_js;
  logic       w_ld;

  always_comb begin
    w_lu_hit = hz.MentoRegtoEX & hz.RegWrtoEX & (hz.rttoEX != 5'd0) &
               ((hz.use_rs & (hz.rttoEX == hz.rs)) | (hz.use_rt & (hz.rttoEX == hz.rt)));
    w_js     = hz.redirect_ex | (r_state == ST_FLUSH);
    w_ld     = ~w_js & (w_lu_hit | (r_state == ST_STALL));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    // A redirect restarts the flush from any state, aborting a stall in progress.
    if (hz.redirect_ex) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_rem_nxt   = 3'(FLUSH_CYCLES - 2);
      end else begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = 3'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lu_hit && (LOAD_STALL_CYCLES > 1)) begin
            w_state_nxt = ST_STALL;
            w_rem_nxt   = 3'(LOAD_STALL_CYCLES - 2);
          end
        end
        ST_STALL, ST_FLUSH: begin
          if (r_rem == 3'd0) w_state_nxt = ST_IDLE;
          else               w_rem_nxt   = r_rem - 3'd1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_rem_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign hz.loadad      = w_ld;
  assign hz.jumpSuccess = w_js;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_ld) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_js) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule
